// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, state encoding and IR field positions
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_ALU     = 2'd1,
    CLS_MULDIV  = 2'd2,
    CLS_HALT    = 2'd3
  } op_class_t;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_SHL = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1010;
  localparam logic [3:0] ALU_DIV = 4'b1011;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_NOP;
    endcase
  endfunction

  // mul/div only decode when the build enables them; otherwise they trap as illegal
  function automatic op_class_t classify(input logic [4:0] op, input logic muldiv_en);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return CLS_ALU;
      OP_MUL, OP_DIV: return muldiv_en ? CLS_MULDIV : CLS_ILLEGAL;
      OP_HALT: return CLS_HALT;
      default: return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath control bundle between sequencer (master) and datapath (slave)
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
  logic        Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [3:0]  operation;
  logic        Run, Illegal;
  logic [15:0] Instr_count;

  modport master (
    input  IR, Mem_ready,
    output PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
    output Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin,
    output Rin, Rout, operation, Run, Illegal, Instr_count
  );

  modport slave (
    output IR, Mem_ready,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
    input  Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin,
    input  Rin, Rout, operation, Run, Illegal, Instr_count
  );
endinterface

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register index to 16-bit one-hot select, gated by enable
module reg_select_decoder (
  input  logic [3:0]  index,
  input  logic        enable,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T0..T6 microsequencer driving DataPath strobes; MULDIV_EN enables mul/div
module control_sequencer
  import cpu_pkg::*;
(
  input logic                 Clock,
  input logic                 clear,
  control_sequencer_if.master ctl
);

`ifdef MULDIV_EN
  localparam logic MULDIV_ON = 1'b1;
`else
  localparam logic MULDIV_ON = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        t1_first_q;
  logic [15:0] instr_count_q;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc, rout_idx;
  logic        rin_en, rout_en, retire;
  op_class_t   op_class;
  logic        unused_ir;

  assign opcode    = ctl.IR[IR_OP_HI:IR_OP_LO];
  assign ra        = ctl.IR[IR_RA_HI:IR_RA_LO];
  assign rb        = ctl.IR[IR_RB_HI:IR_RB_LO];
  assign rc        = ctl.IR[IR_RC_HI:IR_RC_LO];
  assign unused_ir = ^ctl.IR[IR_RC_LO-1:0];
  assign op_class  = classify(opcode, MULDIV_ON);

  // t1_first_q marks the first T1 cycle, the only one allowed to load PC
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q       <= ST_T0;
      t1_first_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      t1_first_q <= (state_q == ST_T0);
      if (retire) instr_count_q <= instr_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    ctl.PCout     = 1'b0;
    ctl.Zlowout   = 1'b0;
    ctl.Zhighout  = 1'b0;
    ctl.MDRout    = 1'b0;
    ctl.MARin     = 1'b0;
    ctl.PCin      = 1'b0;
    ctl.MDRin     = 1'b0;
    ctl.IRin      = 1'b0;
    ctl.Yin       = 1'b0;
    ctl.IncPC     = 1'b0;
    ctl.Read      = 1'b0;
    ctl.Zin_low   = 1'b0;
    ctl.Zin_high  = 1'b0;
    ctl.HIin      = 1'b0;
    ctl.LOin      = 1'b0;
    ctl.operation = ALU_NOP;
    ctl.Illegal   = 1'b0;
    rin_en        = 1'b0;
    rout_en       = 1'b0;
    rout_idx      = rb;
    case (state_q)
      ST_T0: begin
        ctl.PCout   = 1'b1;
        ctl.MARin   = 1'b1;
        ctl.IncPC   = 1'b1;
        ctl.Zin_low = 1'b1;
        state_d     = ST_T1;
      end
      ST_T1: begin
        ctl.Read    = 1'b1;
        ctl.Zlowout = t1_first_q;
        ctl.PCin    = t1_first_q;
        ctl.MDRin   = ctl.Mem_ready;
        if (ctl.Mem_ready) state_d = ST_T2;
      end
      ST_T2: begin
        ctl.MDRout = 1'b1;
        ctl.IRin   = 1'b1;
        state_d    = ST_T3;
      end
      ST_T3: begin
        rout_en  = 1'b1;
        rout_idx = rb;
        ctl.Yin  = 1'b1;
        case (op_class)
          CLS_ILLEGAL: begin
            ctl.Illegal = 1'b1;
            state_d     = ST_T0;
          end
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_T4;
        endcase
      end
      ST_T4: begin
        rout_en       = 1'b1;
        rout_idx      = rc;
        ctl.operation = alu_code(opcode);
        ctl.Zin_low   = 1'b1;
`ifdef MULDIV_EN
        if (op_class == CLS_MULDIV) ctl.Zin_high = 1'b1;
`endif
        state_d = ST_T5;
      end
      ST_T5: begin
        ctl.Zlowout = 1'b1;
        rin_en      = 1'b1;
        state_d     = ST_T0;
`ifdef MULDIV_EN
        if (op_class == CLS_MULDIV) begin
          rin_en   = 1'b0;
          ctl.LOin = 1'b1;
          state_d  = ST_T6;
        end
`endif
      end
      ST_T6: begin
`ifdef MULDIV_EN
        ctl.Zhighout = 1'b1;
        ctl.HIin     = 1'b1;
`endif
        state_d = ST_T0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  assign retire          = (state_d == ST_T0) && ((state_q == ST_T5) || (state_q == ST_T6));
  assign ctl.Run         = (state_q != ST_HALT);
  assign ctl.Instr_count = instr_count_q;

  reg_select_decoder u_rin_dec (
    .index  (ra),
    .enable (rin_en),
    .onehot (ctl.Rin)
  );

  reg_select_decoder u_rout_dec (
    .index  (rout_idx),
    .enable (rout_en),
    .onehot (ctl.Rout)
  );

endmodule
